// File: rtl/serial_sub_n.sv
// Bit-serial subtractor: one full-subtractor cell computes {BOUT,DIFF} = A - B - BIN,
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_sub_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic d_bit;
  logic br_nxt;
  logic last_bit;

  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        // Only WIDTH-1 result bits are kept; the final bit goes straight into DIFF.
        res_d = (WIDTH-1)'({d_bit, res_q} >> 1);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = S_DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {d_bit, res_q};
          bout_d  = br_nxt;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign DIFF = diff_q;
  assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed and randomized checks of serial_sub_n at WIDTH=4 and WIDTH=8 against
// an arithmetic reference of A - B - BIN modulo 2^(WIDTH+1).
module tb_serial_sub_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned done_cnt4 = 0;
  int unsigned done_cnt8 = 0;
  int unsigned exp_done4 = 0;
  int unsigned exp_done8 = 0;

  serial_sub_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .BIN(bin4),
    .busy(busy4), .done(done4), .DIFF(diff4), .BOUT(bout4)
  );

  serial_sub_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .BIN(bin8),
    .busy(busy8), .done(done8), .DIFF(diff8), .BOUT(bout8)
  );

  always @(negedge clk) begin
    if (done4 === 1'b1) done_cnt4++;
    if (done8 === 1'b1) done_cnt8++;
  end

  function automatic int unsigned ref_sub(int unsigned a, int unsigned b,
                                          int unsigned bin, int unsigned w);
    int unsigned m;
    m = 1 << (w + 1);
    return (a + m - b - bin) % m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=4 operation from IDLE, ending in the IDLE cycle after done.
  task automatic run4(input int unsigned a, input int unsigned b, input int unsigned bin);
    int unsigned cyc;
    int unsigned busy_cnt;
    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = 1'b1;
    step();
    start4 = 1'b0;
    exp_done4++;
    cyc = 0; busy_cnt = 0;
    while (done4 !== 1'b1 && cyc < 20) begin
      if (busy4 === 1'b1) busy_cnt++;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      step();
      cyc++;
    end
    chk("w4_latency", cyc, 4);
    chk("w4_busy_cycles", busy_cnt, 4);
    chk("w4_result", {27'd0, bout4, diff4}, ref_sub(a, b, bin, 4));
    step();
    chk("w4_done_pulse", {31'd0, done4}, 0);
  endtask

  task automatic run8(input int unsigned a, input int unsigned b, input int unsigned bin);
    int unsigned cyc;
    a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin); start8 = 1'b1;
    step();
    start8 = 1'b0;
    exp_done8++;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 30) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      step();
      cyc++;
    end
    chk("w8_latency", cyc, 8);
    chk("w8_result", {23'd0, bout8, diff8}, ref_sub(a, b, bin, 8));
    step();
  endtask

  initial begin
    int unsigned d0;
    int unsigned cyc;

    // Reset with random inputs toggling.
    rst = 1'b1;
    start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    step();
    chk("rst_busy", {31'd0, busy4}, 0);
    chk("rst_done", {31'd0, done4}, 0);
    chk("rst_diff", {28'd0, diff4}, 0);
    chk("rst_bout", {31'd0, bout4}, 0);
    chk("rst_busy8", {31'd0, busy8}, 0);
    start4 = 1'($urandom); a4 = 4'($urandom);
    step();
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy4}, 0);

    // Directed operations.
    run4(9, 3, 0);
    chk("dir_9_3", {27'd0, bout4, diff4}, 5'h06);
    run4(3, 9, 0);
    chk("dir_3_9", {27'd0, bout4, diff4}, 5'h1A);
    run4(0, 0, 1);
    chk("dir_0_0_1", {27'd0, bout4, diff4}, 5'h1F);
    run4(15, 15, 0);
    chk("dir_f_f", {27'd0, bout4, diff4}, 5'h00);

    // start during SHIFT and DONE must be ignored.
    d0 = done_cnt4;
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    exp_done4++;
    step();
    a4 = 4'd1; b4 = 4'd5; start4 = 1'b1;
    step();
    start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("ign_result", {27'd0, bout4, diff4}, 5'h05);
    a4 = 4'd1; b4 = 4'd5; start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("ign_done_start", {31'd0, busy4}, 0);
    chk("ign_done_count", done_cnt4 - d0, 1);
    run4(1, 5, 0);

    // Reset mid-SHIFT aborts with no done.
    run4(15, 2, 1);
    d0 = done_cnt4;
    a4 = 4'd12; b4 = 4'd4; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy4}, 0);
    chk("abort_done", {31'd0, done4}, 0);
    chk("abort_diff", {28'd0, diff4}, 0);
    chk("abort_bout", {31'd0, bout4}, 0);
    for (int i = 0; i < 8; i++) step();
    chk("abort_no_done", done_cnt4 - d0, 0);
    run4(12, 4, 0);

    // rst and start on the same edge: rst wins.
    a4 = 4'd3; b4 = 4'd1; start4 = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start4 = 1'b0;
    chk("rst_start_busy", {31'd0, busy4}, 0);

    // Exhaustive WIDTH=4.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(a, b, c);

    // Random WIDTH=8.
    for (int i = 0; i < 1500; i++)
      run8($urandom_range(255), $urandom_range(255), $urandom_range(1));
    run8(0, 255, 1);
    run8(255, 0, 0);

    step();
    chk("w4_done_count", done_cnt4, exp_done4);
    chk("w8_done_count", done_cnt8, exp_done8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
